// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encodings, requester select codes and size defaults
// for the two-writer / one-reader FIFO arbiter.
package fifo_arb_pkg;

   localparam int unsigned DW_DEF    = 32;
   localparam int unsigned DEPTH_DEF = 8;
   localparam int unsigned CNT_W     = 4;   // occupancy / data_count width
   localparam int unsigned NREQ      = 3;   // W0, W1, RD

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      GNT_W0 = 3'b001,
      GNT_W1 = 3'b010,
      GNT_RD = 3'b011
   } state_t;

   // One-hot requester codes shared by the picker and the pointer register
   localparam logic [NREQ-1:0] SEL_W0 = 3'b001;
   localparam logic [NREQ-1:0] SEL_W1 = 3'b010;
   localparam logic [NREQ-1:0] SEL_RD = 3'b100;

endpackage

// File: rtl/fifo_arb_rr.sv
// fifo_arb_rr: combinational 3-way round-robin picker.
//   elig : eligible requesters {RD, W1, W0}
//   last : one-hot last-granted requester
//   pick : one-hot winner, zero when nothing is eligible
module fifo_arb_rr
   import fifo_arb_pkg::*;
(
   input  logic [NREQ-1:0] elig,
   input  logic [NREQ-1:0] last,
   output logic [NREQ-1:0] pick
);

   // Search order starts with the requester after the last winner
   always_comb begin
      pick = '0;
      case (last)
         SEL_W0: begin
            if      (elig[1]) pick = SEL_W1;
            else if (elig[2]) pick = SEL_RD;
            else if (elig[0]) pick = SEL_W0;
         end
         SEL_W1: begin
            if      (elig[2]) pick = SEL_RD;
            else if (elig[0]) pick = SEL_W0;
            else if (elig[1]) pick = SEL_W1;
         end
         default: begin
            if      (elig[0]) pick = SEL_W0;
            else if (elig[1]) pick = SEL_W1;
            else if (elig[2]) pick = SEL_RD;
         end
      endcase
   end

endmodule

// File: rtl/fifo_arb.sv
// fifo_arb: arbitrates two writers and one reader onto a downstream FIFO with
// one-cycle grant latency, tracks occupancy locally and flags any mismatch
// against the FIFO's own count.
//   clk, reset_n              : clock, synchronous active-low reset
//   wr_req0/1, wr_data0/1     : writer requests (level) and data
//   rd_req                    : reader request (level)
//   data_count                : occupancy reported by the FIFO
//   wr_gnt0/1, rd_gnt         : registered one-cycle grant pulses
//   fifo_wr_en, fifo_rd_en    : registered FIFO strobes, aligned with grants
//   fifo_din                  : registered write data, held between writes
//   sync_err                  : sticky occupancy-mismatch flag
module fifo_arb
   import fifo_arb_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_req0,
   input  logic             wr_req1,
   input  logic [DW-1:0]    wr_data0,
   input  logic [DW-1:0]    wr_data1,
   input  logic             rd_req,
   input  logic [CNT_W-1:0] data_count,
   output logic             wr_gnt0,
   output logic             wr_gnt1,
   output logic             rd_gnt,
   output logic             fifo_wr_en,
   output logic             fifo_rd_en,
   output logic [DW-1:0]    fifo_din,
   output logic             sync_err
);

   state_t           state, nxt_state;
   logic [NREQ-1:0]  last, cur_last, elig, pick;
   logic [CNT_W-1:0] occ;
   logic [CNT_W:0]   eff;
   logic             wr_ok, rd_ok;
   logic             gnt0_d, gnt1_d, rgnt_d;
   logic [DW-1:0]    din_d;

   // Occupancy as it will be once this cycle's strobes land
   assign eff   = (CNT_W+1)'(occ) + (CNT_W+1)'(fifo_wr_en) - (CNT_W+1)'(fifo_rd_en);
   assign wr_ok = eff < (CNT_W+1)'(DEPTH);
   assign rd_ok = eff != '0;
   assign elig  = {rd_req & rd_ok, wr_req1 & wr_ok, wr_req0 & wr_ok};

   // A grant state is itself the newest pointer value; the register holds it through IDLE
   always_comb begin
      cur_last = last;
      case (state)
         GNT_W0:  cur_last = SEL_W0;
         GNT_W1:  cur_last = SEL_W1;
         GNT_RD:  cur_last = SEL_RD;
         default: cur_last = last;
      endcase
   end

   fifo_arb_rr u_rr (
      .elig (elig),
      .last (cur_last),
      .pick (pick)
   );

   // State and pointer register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         last  <= SEL_RD;
      end else begin
         state <= nxt_state;
         last  <= cur_last;
      end
   end

   // Next state: every grant lasts one cycle, the winner decides what follows
   always_comb begin
      nxt_state = IDLE;
      case (pick)
         SEL_W0:  nxt_state = GNT_W0;
         SEL_W1:  nxt_state = GNT_W1;
         SEL_RD:  nxt_state = GNT_RD;
         default: nxt_state = IDLE;
      endcase
   end

   // Output decode of the upcoming state, loaded into the output registers
   always_comb begin
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
      rgnt_d = 1'b0;
      din_d  = fifo_din;
      case (nxt_state)
         GNT_W0: begin
            gnt0_d = 1'b1;
            din_d  = wr_data0;
         end
         GNT_W1: begin
            gnt1_d = 1'b1;
            din_d  = wr_data1;
         end
         GNT_RD:  rgnt_d = 1'b1;
         default: ;
      endcase
   end

   // Output registers, occupancy counter and sync check
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_gnt0    <= 1'b0;
         wr_gnt1    <= 1'b0;
         rd_gnt     <= 1'b0;
         fifo_wr_en <= 1'b0;
         fifo_rd_en <= 1'b0;
         fifo_din   <= '0;
         occ        <= '0;
         sync_err   <= 1'b0;
      end else begin
         wr_gnt0    <= gnt0_d;
         wr_gnt1    <= gnt1_d;
         rd_gnt     <= rgnt_d;
         fifo_wr_en <= gnt0_d | gnt1_d;
         fifo_rd_en <= rgnt_d;
         fifo_din   <= din_d;
         if (fifo_wr_en && !fifo_rd_en && occ != CNT_W'(DEPTH))
            occ <= occ + CNT_W'(1);
         else if (fifo_rd_en && !fifo_wr_en && occ != '0)
            occ <= occ - CNT_W'(1);
         if (occ != data_count)
            sync_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_arb.sv
// tb_fifo_arb: directed scenarios for fifo_arb with a behavioural downstream
// FIFO counter driving data_count.
module tb_fifo_arb;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_req0, wr_req1, rd_req;
   logic [DW-1:0] wr_data0, wr_data1;
   logic [3:0]    data_count;
   logic          wr_gnt0, wr_gnt1, rd_gnt;
   logic          fifo_wr_en, fifo_rd_en;
   logic [DW-1:0] fifo_din;
   logic          sync_err;

   logic [3:0]    fifo_cnt;
   logic          ovr_en;
   logic [3:0]    ovr_val;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   fifo_arb #(.DW(DW), .DEPTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_req0    (wr_req0),
      .wr_req1    (wr_req1),
      .wr_data0   (wr_data0),
      .wr_data1   (wr_data1),
      .rd_req     (rd_req),
      .data_count (data_count),
      .wr_gnt0    (wr_gnt0),
      .wr_gnt1    (wr_gnt1),
      .rd_gnt     (rd_gnt),
      .fifo_wr_en (fifo_wr_en),
      .fifo_rd_en (fifo_rd_en),
      .fifo_din   (fifo_din),
      .sync_err   (sync_err)
   );

   // Downstream FIFO occupancy, shares reset_n; ovr_en lets a test corrupt it
   always @(posedge clk) begin
      if (!reset_n) fifo_cnt <= 4'd0;
      else          fifo_cnt <= fifo_cnt + 4'(fifo_wr_en) - 4'(fifo_rd_en);
   end
   assign data_count = ovr_en ? ovr_val : fifo_cnt;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      wr_req0 = 1'b0;
      wr_req1 = 1'b0;
      rd_req  = 1'b0;
      ovr_en  = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      wr_req0  = 1'b1;
      wr_req1  = 1'b1;
      rd_req   = 1'b1;
      wr_data0 = 32'hDEAD_BEEF;
      wr_data1 = 32'h1234_5678;
      ovr_en   = 1'b0;
      ovr_val  = 4'd0;
      repeat (3) step();
      checks++;
      if ({wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en, sync_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 000000",
                  {wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en, sync_err});
      end
      checks++;
      if (fifo_din !== 32'h0) begin
         errors++;
         $display("FAIL reset_din: got %h want 00000000", fifo_din);
      end
      apply_reset();
   endtask

   task automatic test_single_write();
      wr_req0  = 1'b1;
      wr_data0 = 32'h0000_00A5;
      step();
      wr_req0 = 1'b0;
      checks++;
      if ({wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en} !== 5'b10010) begin
         errors++;
         $display("FAIL single_write_gnt: got %b want 10010",
                  {wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en});
      end
      checks++;
      if (fifo_din !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL single_write_din: got %h want 000000a5", fifo_din);
      end
      step();
      checks++;
      if ({wr_gnt0, fifo_wr_en} !== 2'b00 || fifo_din !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL single_write_after: got gnt0=%b wr_en=%b din=%h want 0 0 000000a5",
                  wr_gnt0, fifo_wr_en, fifo_din);
      end
      checks++;
      if (dut.occ !== 4'd1 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL single_write_occ: got occ=%0d sync_err=%b want 1 0", dut.occ, sync_err);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp;
      apply_reset();
      wr_data0 = 32'h11;
      wr_data1 = 32'h22;
      wr_req0  = 1'b1;
      wr_req1  = 1'b1;
      rd_req   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         exp = 3'(1 << (i % 3));
         checks++;
         if ({rd_gnt, wr_gnt1, wr_gnt0} !== exp ||
             {fifo_rd_en, fifo_wr_en} !== {exp[2], exp[1] | exp[0]}) begin
            errors++;
            $display("FAIL rr_seq[%0d]: got gnt=%b en=%b%b want gnt=%b", i,
                     {rd_gnt, wr_gnt1, wr_gnt0}, fifo_rd_en, fifo_wr_en, exp);
         end
         if (exp[0] || exp[1]) begin
            checks++;
            if (fifo_din !== (exp[0] ? 32'h11 : 32'h22)) begin
               errors++;
               $display("FAIL rr_din[%0d]: got %h want %h", i, fifo_din,
                        exp[0] ? 32'h11 : 32'h22);
            end
         end
      end
      wr_req0 = 1'b0;
      wr_req1 = 1'b0;
      rd_req  = 1'b0;
   endtask

   task automatic test_full();
      int wcount;
      int late;
      apply_reset();
      wr_req0 = 1'b1;
      wr_req1 = 1'b1;
      wcount  = 0;
      late    = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (wr_gnt0 || wr_gnt1) begin
            wcount++;
            if (i >= 8) late++;
         end
      end
      checks++;
      if (wcount !== 8 || late !== 0) begin
         errors++;
         $display("FAIL full_writes: got %0d grants (%0d after full) want 8 (0)", wcount, late);
      end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      checks++;
      if ({rd_gnt, wr_gnt1, wr_gnt0} !== 3'b100) begin
         errors++;
         $display("FAIL full_read: got %b want 100", {rd_gnt, wr_gnt1, wr_gnt0});
      end
      step();
      checks++;
      if ({rd_gnt, wr_gnt1, wr_gnt0} !== 3'b001) begin
         errors++;
         $display("FAIL full_refill: got %b want 001", {rd_gnt, wr_gnt1, wr_gnt0});
      end
      wcount = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (wr_gnt0 || wr_gnt1) wcount++;
      end
      checks++;
      if (wcount !== 0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL full_hold: got %0d extra grants sync_err=%b want 0 0", wcount, sync_err);
      end
      wr_req0 = 1'b0;
      wr_req1 = 1'b0;
   endtask

   task automatic test_empty_read();
      int rcount;
      apply_reset();
      rd_req = 1'b1;
      rcount = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (rd_gnt) rcount++;
      end
      checks++;
      if (rcount !== 0) begin
         errors++;
         $display("FAIL empty_read: got %0d read grants want 0", rcount);
      end
      wr_req0  = 1'b1;
      wr_data0 = 32'h77;
      step();
      wr_req0 = 1'b0;
      checks++;
      if ({rd_gnt, wr_gnt1, wr_gnt0} !== 3'b001) begin
         errors++;
         $display("FAIL empty_fill: got %b want 001", {rd_gnt, wr_gnt1, wr_gnt0});
      end
      step();
      rd_req = 1'b0;
      checks++;
      if ({rd_gnt, fifo_rd_en, fifo_wr_en} !== 3'b110) begin
         errors++;
         $display("FAIL empty_then_read: got %b want 110", {rd_gnt, fifo_rd_en, fifo_wr_en});
      end
      step();
      checks++;
      if (rd_gnt !== 1'b0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL empty_drained: got rd_gnt=%b sync_err=%b want 0 0", rd_gnt, sync_err);
      end
   endtask

   task automatic test_sync_err();
      int drops;
      apply_reset();
      wr_req0 = 1'b1;
      step();
      step();
      wr_req0 = 1'b0;
      step();
      checks++;
      if (sync_err !== 1'b0 || data_count !== 4'd2) begin
         errors++;
         $display("FAIL sync_before: got sync_err=%b count=%0d want 0 2", sync_err, data_count);
      end
      ovr_val = 4'd3;
      ovr_en  = 1'b1;
      step();
      ovr_en = 1'b0;
      checks++;
      if (sync_err !== 1'b1) begin
         errors++;
         $display("FAIL sync_set: got %b want 1", sync_err);
      end
      drops = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (sync_err !== 1'b1) drops++;
      end
      checks++;
      if (drops !== 0) begin
         errors++;
         $display("FAIL sync_sticky: got %0d cleared cycles want 0", drops);
      end
      reset_n = 1'b0;
      step();
      checks++;
      if (sync_err !== 1'b0) begin
         errors++;
         $display("FAIL sync_reset: got %b want 0", sync_err);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_reset_mid_grant();
      apply_reset();
      wr_req1  = 1'b1;
      wr_data1 = 32'h5A;
      step();
      checks++;
      if ({rd_gnt, wr_gnt1, wr_gnt0} !== 3'b010 || fifo_din !== 32'h5A) begin
         errors++;
         $display("FAIL mid_w1_gnt: got gnt=%b din=%h want 010 0000005a",
                  {rd_gnt, wr_gnt1, wr_gnt0}, fifo_din);
      end
      reset_n  = 1'b0;
      wr_req0  = 1'b1;
      wr_data0 = 32'hC3;
      step();
      checks++;
      if ({wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en, sync_err} !== 6'b0 ||
          fifo_din !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset: got %b din=%h want 000000 00000000",
                  {wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en, sync_err}, fifo_din);
      end
      reset_n = 1'b1;
      step();
      checks++;
      if ({rd_gnt, wr_gnt1, wr_gnt0} !== 3'b001 || fifo_din !== 32'hC3) begin
         errors++;
         $display("FAIL mid_rearb: got gnt=%b din=%h want 001 000000c3",
                  {rd_gnt, wr_gnt1, wr_gnt0}, fifo_din);
      end
      step();
      checks++;
      if ({rd_gnt, wr_gnt1, wr_gnt0} !== 3'b010) begin
         errors++;
         $display("FAIL mid_second: got %b want 010", {rd_gnt, wr_gnt1, wr_gnt0});
      end
      wr_req0 = 1'b0;
      wr_req1 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want end of test");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_full();
      test_empty_read();
      test_sync_err();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
